// File: rtl/dlx_fetch_pkg.sv
// Shared types and constants for the instruction-fetch bus master.
package dlx_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRelease,
        StDeliver
    } fetch_state_e;

    localparam int unsigned TimeoutDefault = 15;

    // Low PC bits that must be zero for a word-aligned fetch.
    localparam logic [1:0] AlignMask = 2'b11;

    function automatic logic is_aligned(input logic [1:0] pc_lsbs);
        return (pc_lsbs & AlignMask) == 2'b00;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Handshake-phase cycle counter; expired flags the last permitted wait cycle.
module bus_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CntLast);

endmodule

// File: rtl/ifetch_bus_master.sv
// Instruction-fetch bus master: 4-phase MREQ/MACK read, then a single IRCE load
// pulse toward the instruction register.
module ifetch_bus_master
    import dlx_fetch_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FETCH,
    input  logic [ADDR_W-1:0] PC,
    input  logic              MACK,
    input  logic [DATA_W-1:0] MDATA,
    input  logic              IR_READY,
    output logic              MREQ,
    output logic [ADDR_W-1:0] MADDR,
    output logic [DATA_W-1:0] DI_OUT,
    output logic              IRCE,
    output logic              BUSY,
    output logic              FETCH_ERR
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] di_q, di_d;
    logic              mreq_q, mreq_d;
    logic              err_q, err_d;
    logic              tmr_clr, tmr_inc, tmr_expired;
    logic              pc_aligned;

    assign pc_aligned = is_aligned(PC[1:0]);

    bus_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_bus_timer (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .clr_i    (tmr_clr),
        .inc_i    (tmr_inc),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        maddr_d = maddr_q;
        di_d    = di_q;
        mreq_d  = mreq_q;
        err_d   = err_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        IRCE    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (FETCH) begin
                    if (!pc_aligned) begin
                        err_d = 1'b1;
                    end else if (!MACK) begin
                        // A still-high MACK is a stale ack; wait for it to clear.
                        maddr_d = PC;
                        mreq_d  = 1'b1;
                        err_d   = 1'b0;
                        tmr_clr = 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (MACK) begin
                    di_d    = MDATA;
                    mreq_d  = 1'b0;
                    tmr_clr = 1'b1;
                    state_d = StRelease;
                end else if (tmr_expired) begin
                    mreq_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            StRelease: begin
                if (!MACK) begin
                    state_d = StDeliver;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            StDeliver: begin
                if (IR_READY) begin
                    IRCE = 1'b1;
                    if (FETCH && pc_aligned) begin
                        maddr_d = PC;
                        mreq_d  = 1'b1;
                        err_d   = 1'b0;
                        tmr_clr = 1'b1;
                        state_d = StReq;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                mreq_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            maddr_q <= '0;
            di_q    <= '0;
            mreq_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            maddr_q <= maddr_d;
            di_q    <= di_d;
            mreq_q  <= mreq_d;
            err_q   <= err_d;
        end
    end

    assign MREQ      = mreq_q;
    assign MADDR     = maddr_q;
    assign DI_OUT    = di_q;
    assign BUSY      = (state_q != StIdle);
    assign FETCH_ERR = err_q;

endmodule

// File: tb/tb_ifetch_bus_master.sv
// Scoreboard bench for ifetch_bus_master: a behavioural memory answers the
// handshake, expected deliveries are queued at issue and popped on each IRCE.
module tb_ifetch_bus_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 15;

    logic          CLK = 1'b0;
    logic          RESET, FETCH, MACK, IR_READY;
    logic [AW-1:0] PC;
    logic [DW-1:0] MDATA;
    logic          MREQ, IRCE, BUSY, FETCH_ERR;
    logic [AW-1:0] MADDR;
    logic [DW-1:0] DI_OUT;

    ifetch_bus_master #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .FETCH    (FETCH),
        .PC       (PC),
        .MACK     (MACK),
        .MDATA    (MDATA),
        .IR_READY (IR_READY),
        .MREQ     (MREQ),
        .MADDR    (MADDR),
        .DI_OUT   (DI_OUT),
        .IRCE     (IRCE),
        .BUSY     (BUSY),
        .FETCH_ERR(FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    bit   [31:0] mem[bit [31:0]];
    int          total = 0;
    int          bad = 0;
    int          irce_cnt = 0;
    int          n_push = 0;
    // Memory behaviour: 0 normal, 1 never ack, 2 ack never released, 3 MACK = mack_force.
    int          mem_mode = 0;
    int          ack_dly = 0;
    bit          mack_force = 0;
    bit          rdy_rand = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hBAD0_0000 ^ a;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (BUSY && n < bound) begin
            tick();
            n++;
        end
        if (BUSY) begin
            total++;
            bad++;
            $display("FAIL wait_idle: still busy after %0d cycles", bound);
        end
    endtask

    // Issues one aligned fetch from IDLE; push=1 queues the expected delivery.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input bit push);
        wait_idle(200);
        mem[pc] = data;
        FETCH = 1'b1;
        PC    = pc;
        tick();
        FETCH = 1'b0;
        check("accept_busy_mreq", {30'd0, BUSY, MREQ}, 32'd3);
        check("accept_maddr", MADDR, pc);
        check("accept_err_clear", {31'd0, FETCH_ERR}, 32'd0);
        if (push) begin
            sb.push_back('{addr: pc, data: data});
            n_push++;
        end
    endtask

    // Behavioural memory responder.
    initial begin
        int wait_cnt = 0;
        MACK  = 1'b0;
        MDATA = '0;
        forever begin
            @(negedge CLK);
            case (mem_mode)
                0: begin
                    if (MREQ && !MACK) begin
                        if (wait_cnt >= ack_dly) begin
                            MACK     = 1'b1;
                            MDATA    = mem_rd(MADDR);
                            wait_cnt = 0;
                        end else begin
                            wait_cnt++;
                        end
                    end else if (!MREQ) begin
                        MACK     = 1'b0;
                        wait_cnt = 0;
                    end
                end
                1: MACK = 1'b0;
                2: begin
                    if (MREQ) begin
                        MACK  = 1'b1;
                        MDATA = mem_rd(MADDR);
                    end
                end
                default: MACK = mack_force;
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rdy_rand) IR_READY = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every IRCE pulse must match the oldest outstanding fetch.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET && IRCE) begin
                irce_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_irce: got pulse, expected none (DI_OUT=%h)", DI_OUT);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("deliver_data", DI_OUT, e.data);
                    check("deliver_addr", MADDR, e.addr);
                end
            end
        end
    end

    initial begin
        int n;
        int base;
        logic [31:0] w;

        RESET    = 1'b1;
        FETCH    = 1'b0;
        PC       = '0;
        IR_READY = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_mreq", {31'd0, MREQ}, 32'd0);
        check("rst_maddr", MADDR, 32'd0);
        check("rst_di_out", DI_OUT, 32'd0);
        check("rst_irce_busy_err", {29'd0, IRCE, BUSY, FETCH_ERR}, 32'd0);
        RESET = 1'b0;
        tick();

        // Single fetch with minimum latency.
        IR_READY = 1'b1;
        base = irce_cnt;
        do_fetch(32'h40, 32'h8C01_0011, 1'b1);
        tick();
        check("single_e1_mreq_busy", {30'd0, MREQ, BUSY}, 32'd1);
        tick();
        check("single_e2_irce", {31'd0, IRCE}, 32'd1);
        check("single_e2_di", DI_OUT, 32'h8C01_0011);
        tick();
        check("single_e3_busy_irce", {30'd0, BUSY, IRCE}, 32'd0);
        check("single_pulses", irce_cnt - base, 32'd1);

        // IR stall for four cycles.
        IR_READY = 1'b0;
        w = 32'h1234_5678;
        base = irce_cnt;
        do_fetch(32'h48, w, 1'b1);
        n = 0;
        while (!(BUSY && !MREQ && !MACK) && n < 20) begin
            tick();
            n++;
        end
        check("stall_reached_deliver", {31'd0, BUSY && !MREQ && !MACK}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("stall_irce_low", {31'd0, IRCE}, 32'd0);
            check("stall_di_held", DI_OUT, w);
            tick();
        end
        IR_READY = 1'b1;
        #1;
        check("stall_irce_high", {31'd0, IRCE}, 32'd1);
        tick();
        check("stall_done_busy", {31'd0, BUSY}, 32'd0);
        check("stall_pulses", irce_cnt - base, 32'd1);

        // Back-to-back: FETCH held with the next PC across the IRCE edge.
        base = irce_cnt;
        mem[32'h40] = 32'h8C01_0011;
        mem[32'h44] = 32'h0043_2023;
        FETCH = 1'b1;
        PC    = 32'h40;
        tick();
        sb.push_back('{addr: 32'h40, data: 32'h8C01_0011});
        sb.push_back('{addr: 32'h44, data: 32'h0043_2023});
        n_push += 2;
        PC = 32'h44;
        n = 0;
        while (!IRCE && n < 20) begin
            tick();
            n++;
        end
        tick();
        FETCH = 1'b0;
        check("b2b_mreq_busy", {30'd0, MREQ, BUSY}, 32'd3);
        check("b2b_maddr", MADDR, 32'h44);
        wait_idle(50);
        check("b2b_pulses", irce_cnt - base, 32'd2);

        // Misaligned PC, then an aligned fetch clears the error.
        FETCH = 1'b1;
        PC    = 32'h42;
        tick();
        FETCH = 1'b0;
        check("misalign_err_mreq_busy", {29'd0, FETCH_ERR, MREQ, BUSY}, 32'd4);
        tick();
        check("misalign_err_sticky", {29'd0, FETCH_ERR, MREQ, BUSY}, 32'd4);
        do_fetch(32'h50, 32'hCAFE_F00D, 1'b1);
        wait_idle(50);

        // REQ timeout: memory never acknowledges.
        mem_mode = 1;
        base = irce_cnt;
        do_fetch(32'h80, 32'h0, 1'b0);
        n = 1;
        while (n < 40) begin
            tick();
            if (!MREQ) break;
            n++;
        end
        check("req_timeout_cycles", n, TO);
        check("req_timeout_err_busy", {30'd0, FETCH_ERR, BUSY}, 32'd2);
        check("req_timeout_no_irce", irce_cnt - base, 32'd0);
        mem_mode = 0;

        // RELEASE timeout: MACK stuck high after the capture.
        mem_mode = 2;
        w = 32'h5A5A_0F0F;
        do_fetch(32'h90, w, 1'b0);
        tick();
        check("rel_entered", {30'd0, MREQ, BUSY}, 32'd1);
        n = 1;
        while (n < 40) begin
            tick();
            if (!BUSY) break;
            n++;
        end
        check("rel_timeout_cycles", n, TO);
        check("rel_timeout_err", {31'd0, FETCH_ERR}, 32'd1);
        check("rel_timeout_di", DI_OUT, w);
        check("rel_timeout_no_irce", irce_cnt - base, 32'd0);
        mem_mode = 0;
        repeat (2) tick();

        // Reset mid-REQ, then a stale MACK blocks the next fetch until it falls.
        mem_mode = 1;
        do_fetch(32'hA0, 32'h0, 1'b0);
        tick();
        #2;
        RESET = 1'b1;
        #1;
        check("midreset_mreq_busy", {30'd0, MREQ, BUSY}, 32'd0);
        mack_force = 1'b1;
        mem_mode   = 3;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        FETCH = 1'b1;
        PC    = 32'hA4;
        mem[32'hA4] = 32'h0BAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stale_ack_ignored", {30'd0, MREQ, BUSY}, 32'd0);
        end
        mack_force = 1'b0;
        tick();
        check("stale_cleared_accept", {30'd0, MREQ, BUSY}, 32'd3);
        check("stale_cleared_maddr", MADDR, 32'hA4);
        FETCH = 1'b0;
        sb.push_back('{addr: 32'hA4, data: 32'h0BAD_BEEF});
        n_push++;
        mem_mode = 0;
        wait_idle(50);

        // Randomised traffic with random ack delay and IR back-pressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ack_dly = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                wait_idle(200);
                FETCH = 1'b1;
                PC    = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                tick();
                FETCH = 1'b0;
                check("rand_misalign", {29'd0, FETCH_ERR, MREQ, BUSY}, 32'd4);
            end
            do_fetch($urandom & 32'hFFFF_FFFC, $urandom, 1'b1);
        end
        rdy_rand = 1'b0;
        IR_READY = 1'b1;
        wait_idle(200);
        tick();
        check("sb_drained", sb.size(), 32'd0);
        check("total_pulses", irce_cnt, n_push);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
